alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 78 +++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port
// seen by alu_arbiter; the arbiter uses the slave view, the environment the master view.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_A;
  logic [31:0] req0_B;
  logic [2:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_A;
  logic [31:0] req1_B;
  logic [2:0]  req1_op;

  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_ALUOp;
  logic [31:0] alu_C;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_C;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_op,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_op,
    output req1_ready,
    output alu_A, alu_B, alu_ALUOp,
    input  alu_C,
    output rsp_valid, rsp_id, rsp_C,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_op,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_op,
    input  req1_ready,
    input  alu_A, alu_B, alu_ALUOp,
    output alu_C,
    input  rsp_valid, rsp_id, rsp_C,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with a single
// response buffer that sustains one operation per cycle.
module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  logic        r_last_grant;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_C;

  logic        w_buf_free;
  logic        w_any_valid;
  logic        w_grant;
  logic        w_accept;

  // Buffer is reusable when empty or being drained in this same cycle.
  assign w_buf_free  = !r_rsp_valid || bus.rsp_ready;
  assign w_any_valid = bus.req0_valid || bus.req1_valid;
  assign w_accept    = reset && w_buf_free && w_any_valid;

  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = RR ? ~r_last_grant : 1'b0;
    end else if (bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign bus.req0_ready = reset && w_buf_free && bus.req0_valid && !w_grant;
  assign bus.req1_ready = reset && w_buf_free && bus.req1_valid &&  w_grant;

  // Operands follow the grant even while the buffer is blocked.
  always_comb begin
    bus.alu_A     = 32'd0;
    bus.alu_B     = 32'd0;
    bus.alu_ALUOp = 3'd0;
    if (w_any_valid) begin
      if (w_grant) begin
        bus.alu_A     = bus.req1_A;
        bus.alu_B     = bus.req1_B;
        bus.alu_ALUOp = bus.req1_op;
      end else begin
        bus.alu_A     = bus.req0_A;
        bus.alu_B     = bus.req0_B;
        bus.alu_ALUOp = bus.req0_op;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_C      <= 32'd0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_accept) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_C      <= bus.alu_C;
        r_rsp_id     <= w_grant;
        r_last_grant <= w_grant;
      end else if (bus.rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_C     = r_rsp_C;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter driven with
// identical stimulus, each in front of a reference ALU.
module tb_alu_arbiter;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_arbiter_if bus_a ();
  alu_arbiter_if bus_b ();

  alu_arbiter #(.RR(1'b1)) dut_rr (.clk(clk), .reset(reset), .bus(bus_a));
  alu_arbiter #(.RR(1'b0)) dut_fp (.clk(clk), .reset(reset), .bus(bus_b));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a >> b[4:0];
      3'd5:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  assign bus_a.alu_C = alu_f(bus_a.alu_A, bus_a.alu_B, bus_a.alu_ALUOp);
  assign bus_b.alu_C = alu_f(bus_b.alu_A, bus_b.alu_B, bus_b.alu_ALUOp);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    bus_a.req0_valid = v; bus_a.req0_A = a; bus_a.req0_B = b; bus_a.req0_op = op;
    bus_b.req0_valid = v; bus_b.req0_A = a; bus_b.req0_B = b; bus_b.req0_op = op;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    bus_a.req1_valid = v; bus_a.req1_A = a; bus_a.req1_B = b; bus_a.req1_op = op;
    bus_b.req1_valid = v; bus_b.req1_A = a; bus_b.req1_B = b; bus_b.req1_op = op;
  endtask

  task automatic set_rsp_ready(input logic r);
    bus_a.rsp_ready = r;
    bus_b.rsp_ready = r;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    set_req0(1'b1, 32'd7, 32'd5, 3'd1);
    set_req1(1'b0, 32'd0, 32'd0, 3'd0);
    set_rsp_ready(1'b1);

    // Reset state: nothing ready, buffer empty even with a request pending.
    edge1();
    chk("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, bus_a.rsp_id}, 32'd0);
    chk("rst_rsp_C", bus_a.rsp_C, 32'd0);
    chk("rst_req0_ready", {31'd0, bus_a.req0_ready}, 32'd0);
    set_req0(1'b0, 32'd0, 32'd0, 3'd0);
    #3;
    reset = 1'b1;

    // Tie: RR alternates 0,1,0,1; fixed priority always picks 0.
    set_req0(1'b1, 32'd1, 32'd1, 3'd0);
    set_req1(1'b1, 32'hF0, 32'h3C, 3'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie%0d_rr_req0_ready", k), {31'd0, bus_a.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tie%0d_rr_req1_ready", k), {31'd0, bus_a.req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("tie%0d_fp_req1_ready", k), {31'd0, bus_b.req1_ready}, 32'd0);
      edge1();
      chk($sformatf("tie%0d_rr_rsp_valid", k), {31'd0, bus_a.rsp_valid}, 32'd1);
      chk($sformatf("tie%0d_rr_rsp_id", k), {31'd0, bus_a.rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("tie%0d_rr_rsp_C", k), bus_a.rsp_C, (k % 2 == 0) ? 32'd2 : 32'h30);
      chk($sformatf("tie%0d_fp_rsp_id", k), {31'd0, bus_b.rsp_id}, 32'd0);
      chk($sformatf("tie%0d_fp_rsp_C", k), bus_b.rsp_C, 32'd2);
    end
    set_req1(1'b0, 32'd0, 32'd0, 3'd0);

    // Single op from requester 0, accepted while the previous result drains.
    set_req0(1'b1, 32'd7, 32'd5, 3'd1);
    #1;
    chk("single_req0_ready", {31'd0, bus_a.req0_ready}, 32'd1);
    chk("single_req1_ready", {31'd0, bus_a.req1_ready}, 32'd0);
    chk("single_alu_A", bus_a.alu_A, 32'd7);
    chk("single_alu_op", {29'd0, bus_a.alu_ALUOp}, 32'd1);
    edge1();
    set_req0(1'b0, 32'd0, 32'd0, 3'd0);
    chk("single_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
    chk("single_rsp_id", {31'd0, bus_a.rsp_id}, 32'd0);
    chk("single_rsp_C", bus_a.rsp_C, 32'd2);

    // Idle: ALU ports zero, buffer drains and holds its data.
    #1;
    chk("idle_alu_A", bus_a.alu_A, 32'd0);
    chk("idle_alu_B", bus_a.alu_B, 32'd0);
    chk("idle_alu_op", {29'd0, bus_a.alu_ALUOp}, 32'd0);
    edge1();
    chk("idle_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("idle_rsp_C_hold", bus_a.rsp_C, 32'd2);
    edge1();
    chk("idle2_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);

    // Backpressure: last grant was 0, so the tie goes to 1, then everything stalls.
    set_rsp_ready(1'b0);
    set_req0(1'b1, 32'd1, 32'd1, 3'd0);
    set_req1(1'b1, 32'hF0, 32'h3C, 3'd2);
    #1;
    chk("bp_first_req1_ready", {31'd0, bus_a.req1_ready}, 32'd1);
    edge1();
    chk("bp_first_rsp_id", {31'd0, bus_a.rsp_id}, 32'd1);
    chk("bp_first_rsp_C", bus_a.rsp_C, 32'h30);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_req0_ready", k), {31'd0, bus_a.req0_ready}, 32'd0);
      chk($sformatf("bp%0d_req1_ready", k), {31'd0, bus_a.req1_ready}, 32'd0);
      chk($sformatf("bp%0d_fp_req0_ready", k), {31'd0, bus_b.req0_ready}, 32'd0);
      edge1();
      chk($sformatf("bp%0d_rsp_valid", k), {31'd0, bus_a.rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_rsp_C_hold", k), bus_a.rsp_C, 32'h30);
    end
    set_rsp_ready(1'b1);
    #1;
    chk("bp_release_req0_ready", {31'd0, bus_a.req0_ready}, 32'd1);
    edge1();
    chk("bp_release_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
    chk("bp_release_rsp_id", {31'd0, bus_a.rsp_id}, 32'd0);
    chk("bp_release_rsp_C", bus_a.rsp_C, 32'd2);
    set_req0(1'b0, 32'd0, 32'd0, 3'd0);

    // Shifts and pass-through opcodes from requester 1.
    set_req1(1'b1, 32'h8000_0000, 32'd4, 3'd7);
    #1;
    chk("op7_alu_op", {29'd0, bus_a.alu_ALUOp}, 32'd7);
    edge1();
    chk("op7_rsp_C", bus_a.rsp_C, 32'd0);
    chk("op7_rsp_id", {31'd0, bus_a.rsp_id}, 32'd1);
    set_req1(1'b1, 32'h8000_0000, 32'd4, 3'd6);
    edge1();
    chk("op6_rsp_C", bus_a.rsp_C, 32'd0);
    set_req1(1'b1, 32'h8000_0000, 32'd4, 3'd5);
    edge1();
    chk("op5_rsp_C", bus_a.rsp_C, 32'hF800_0000);
    set_req1(1'b1, 32'h8000_0000, 32'd4, 3'd4);
    edge1();
    chk("op4_rsp_C", bus_a.rsp_C, 32'h0800_0000);
    set_req1(1'b0, 32'd0, 32'd0, 3'd0);
    set_rsp_ready(1'b0);

    // Reset mid-operation, asserted between edges.
    #1;
    chk("mid_pre_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
    set_req0(1'b1, 32'd1, 32'd1, 3'd0);
    set_req1(1'b1, 32'hF0, 32'h3C, 3'd2);
    reset = 1'b0;
    #1;
    chk("mid_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("mid_rsp_C", bus_a.rsp_C, 32'd0);
    chk("mid_rsp_id", {31'd0, bus_a.rsp_id}, 32'd0);
    chk("mid_req0_ready", {31'd0, bus_a.req0_ready}, 32'd0);
    chk("mid_req1_ready", {31'd0, bus_a.req1_ready}, 32'd0);
    set_rsp_ready(1'b1);
    edge1();
    chk("mid_held_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("post_rst_req0_ready", {31'd0, bus_a.req0_ready}, 32'd1);
    chk("post_rst_req1_ready", {31'd0, bus_a.req1_ready}, 32'd0);
    edge1();
    chk("post_rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
    chk("post_rst_rsp_id", {31'd0, bus_a.rsp_id}, 32'd0);
    chk("post_rst_rsp_C", bus_a.rsp_C, 32'd2);
    set_req0(1'b0, 32'd0, 32'd0, 3'd0);
    set_req1(1'b0, 32'd0, 32'd0, 3'd0);
    edge1();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
